alu_multicycle: RTL and testbench



---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_multicycle_seq_multiplier.sv | 35 +++
 rtl/alu_multicycle.sv | 138 +++++++++++++
 tb/tb_alu_multicycle.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes and execute-unit FSM state type.
// The alucontrol decoder imports the same code constants.
`timescale 1ns/1ps
package alu_pkg;

  localparam int ALU_OP_W = 4;

  // Operation codes emitted by the ALU control decoder
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_MUL = 4'b1111
  } alu_op_t;

  // Execute unit control state
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_multicycle_seq_multiplier.sv
// seq_multiplier: iterative shift-add multiply datapath.
// load captures the operands and clears the accumulator; each step
// conditionally adds the multiplicand and shifts both operands.
// Control (iteration count, completion) lives in the parent FSM.
`timescale 1ns/1ps
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  // Datapath registers carry no reset: the FSM never reads them before a load
  always_ff @(posedge clk) begin
    if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage execute unit.
// Single-cycle ops produce a registered result one cycle after launch.
// Optional feature macro ALU_MUL_EN compiles in the iterative multiplier
// (code 1111); without it 1111 is answered as an illegal code and busy is 0.
`timescale 1ns/1ps
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  alu_op_t          op;
  logic [WIDTH-1:0] op_result;
  logic             op_illegal;
  logic             launch;
  logic             mul_load;
  logic             mul_finish;
  logic [WIDTH-1:0] mul_acc;

  assign op = alu_op_t'(alucontrol);

  // Combinational single-cycle operations; unknown codes flag illegal with a zero result
  always_comb begin
    op_result  = '0;
    op_illegal = 1'b0;
    case (op)
      ALU_AND: op_result = a & b;
      ALU_OR:  op_result = a | b;
      ALU_ADD: op_result = a + b;
      ALU_SLL: op_result = b << shamt;
      ALU_SUB: op_result = a - b;
      ALU_SLT: op_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: op_result = ~(a | b);
`ifdef ALU_MUL_EN
      ALU_MUL: op_result = '0;
`endif
      default: op_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  // cnt counts completed iterations; the value WIDTH marks the write-back cycle
  localparam int CNT_W = $clog2(WIDTH) + 1;

  alu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             mul_step;

  assign launch     = start && (state == IDLE);
  assign mul_load   = launch && (op == ALU_MUL);
  assign mul_step   = (state == MUL) && (cnt != CNT_W'(WIDTH));
  assign mul_finish = (state == MUL) && (cnt == CNT_W'(WIDTH));
  assign busy       = (state == MUL);

  seq_multiplier #(
    .WIDTH (WIDTH)
  ) u_seq_multiplier (
    .clk  (clk),
    .load (mul_load),
    .step (mul_step),
    .a    (a),
    .b    (b),
    .acc  (mul_acc)
  );

  // Multiply sequencing: WIDTH shift-add iterations, then one write-back cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_load) begin
            state <= MUL;
            cnt   <= '0;
          end
        end
        MUL: begin
          if (mul_finish) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
`else
  assign launch     = start;
  assign mul_load   = 1'b0;
  assign mul_finish = 1'b0;
  assign mul_acc    = '0;
  assign busy       = 1'b0;
`endif

  // Result register: written on single-cycle launch or multiply completion, held otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result  <= '0;
      zero    <= 1'b1;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (mul_finish) begin
        result <= mul_acc;
        zero   <= (mul_acc == '0);
        done   <= 1'b1;
      end else if (launch && !mul_load) begin
        result  <= op_result;
        zero    <= (op_result == '0);
        done    <= 1'b1;
        illegal <= op_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Testbench for alu_multicycle: table-driven single-cycle vectors,
// hand-written multiply corner sequences and randomized operations
// against a behavioural model. Honors ALU_MUL_EN like the design.
`timescale 1ns/1ps
module tb_alu_multicycle;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       alucontrol = 4'h0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [4:0]       shamt = '0;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic             illegal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .shamt      (shamt),
    .result     (result),
    .zero       (zero),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {illegal, result} from the operation definitions
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [4:0] s);
    logic [63:0] p;
    case (op)
      4'b0000: return {1'b0, x & y};
      4'b0001: return {1'b0, x | y};
      4'b0010: return {1'b0, 32'(x + y)};
      4'b0011: return {1'b0, 32'(y << s)};
      4'b0110: return {1'b0, 32'(x - y)};
      4'b0111: return {1'b0, (int'(x) < int'(y)) ? 32'd1 : 32'd0};
      4'b1100: return {1'b0, ~(x | y)};
`ifdef ALU_MUL_EN
      4'b1111: begin
        p = 64'(x) * 64'(y);
        return {1'b0, p[31:0]};
      end
`endif
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // Single-cycle launch: result, zero, done, illegal all valid after one edge
  task automatic single_op(input string name, input logic [3:0] op, input logic [31:0] x,
                           input logic [31:0] y, input logic [4:0] s, input logic [31:0] exp_res,
                           input logic exp_ill);
    start = 1'b1; alucontrol = op; a = x; b = y; shamt = s;
    tick();
    check({name, ".result"}, result, exp_res);
    check({name, ".flags"}, {zero, done, illegal, busy}, {(exp_res == 0), 1'b1, exp_ill, 1'b0});
  endtask

  // Multiply with optional ignored launch at cycle ign_at and optional launch on done
  task automatic run_mul(input logic [31:0] x, input logic [31:0] y, input int ign_at,
                         input bit chain);
    logic [32:0] m;
    m = model(4'b1111, x, y, 5'd0);
    start = 1'b1; alucontrol = 4'b1111; a = x; b = y; shamt = '0;
    tick();
`ifdef ALU_MUL_EN
    check("mul.busy_e", {busy, done}, 2'b10);
    for (int k = 1; k <= WIDTH + 1; k++) begin
      if (k == ign_at) begin
        start = 1'b1; alucontrol = 4'b0010; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'($urandom); alucontrol = 4'($urandom); a = $urandom; b = $urandom;
      end
      tick();
      if (k <= WIDTH) check("mul.busy", {busy, done}, 2'b10);
    end
    check("mul.result", result, {32'd0, m[31:0]});
    check("mul.flags", {zero, done, illegal, busy}, {(m[31:0] == 0), 1'b1, 1'b0, 1'b0});
    if (chain) begin
      start = 1'b1; alucontrol = 4'b0010; a = 32'd1; b = 32'd1;
      tick();
      check("chain.result", result, 32'd2);
      check("chain.done", {done, busy}, 2'b10);
    end else begin
      start = 1'b0;
      tick();
      check("mul.single_done", done, 1'b0);
      check("mul.held", result, {32'd0, m[31:0]});
    end
`else
    check("mul_off.result", result, 32'd0);
    check("mul_off.flags", {zero, done, illegal, busy}, 4'b1110);
    if (chain) begin
      start = 1'b1; alucontrol = 4'b0010; a = 32'd1; b = 32'd1;
      tick();
      check("chain.result", result, 32'd2);
    end
`endif
    start = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  s;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  vec_t vt[13];

  initial begin
    logic [32:0] m;
    logic [3:0]  op;
    logic [31:0] x, y;
    logic [4:0]  s;
    bit          seen;

    vt[0]  = '{4'b0010, 32'd5,        32'd7,        5'd0,  32'd12,       1'b0};
    vt[1]  = '{4'b0110, 32'd3,        32'd3,        5'd0,  32'd0,        1'b0};
    vt[2]  = '{4'b0111, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,        1'b0};
    vt[3]  = '{4'b1100, 32'd0,        32'd0,        5'd0,  32'hFFFFFFFF, 1'b0};
    vt[4]  = '{4'b0011, 32'd0,        32'd1,        5'd31, 32'h80000000, 1'b0};
    vt[5]  = '{4'b0000, 32'hF0F0,     32'hFF00,     5'd0,  32'hF000,     1'b0};
    vt[6]  = '{4'b0001, 32'hF0F0,     32'h0F0F,     5'd0,  32'hFFFF,     1'b0};
    vt[7]  = '{4'b0010, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,        1'b0};
    vt[8]  = '{4'b0110, 32'd0,        32'd1,        5'd0,  32'hFFFFFFFF, 1'b0};
    vt[9]  = '{4'b0111, 32'd1,        32'hFFFFFFFF, 5'd0,  32'd0,        1'b0};
    vt[10] = '{4'b0111, 32'd5,        32'd5,        5'd0,  32'd0,        1'b0};
    vt[11] = '{4'b0100, 32'd9,        32'd9,        5'd0,  32'd0,        1'b1};
    vt[12] = '{4'b1010, 32'd1,        32'd2,        5'd0,  32'd0,        1'b1};

    // Asynchronous reset, checked before any clock edge acts on it
    #1 reset = 1'b1;
    #2;
    check("reset.result", result, 32'd0);
    check("reset.flags", {zero, busy, done, illegal}, 4'b1000);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Back-to-back table vectors, one result per cycle
    foreach (vt[i]) single_op($sformatf("vec%0d", i), vt[i].op, vt[i].x, vt[i].y, vt[i].s,
                              vt[i].res, vt[i].ill);
    start = 1'b0;
    tick();
    check("idle.no_done", {done, illegal}, 2'b00);
    check("idle.held", result, 32'd0);

    // Multiply corners
    run_mul(32'd6, 32'd7, -1, 1'b0);
    run_mul(32'hFFFFFFFF, 32'd2, -1, 1'b0);
    run_mul(32'd123, 32'd0, 10, 1'b0);
    run_mul(32'h12345, 32'h6789, 10, 1'b1);

    // Reset abort mid-multiply
    start = 1'b1; alucontrol = 4'b1111; a = 32'd1000; b = 32'd1000;
    tick();
    start = 1'b0;
    for (int k = 1; k < 15; k++) tick();
    reset = 1'b1;
    #1;
    check("abort.result", result, 32'd0);
    check("abort.flags", {zero, busy, done, illegal}, 4'b1000);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("abort.no_done", seen, 1'b0);
    single_op("abort.add", 4'b0010, 32'd2, 32'd2, 5'd0, 32'd4, 1'b0);
    start = 1'b0;
    tick();

    // Randomized operations against the model
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      x = $urandom; y = $urandom; s = 5'($urandom);
      if (i % 5 == 0) y = x;
      if (op == 4'b1111) begin
        run_mul(x, y, int'($urandom_range(1, 40)), 1'($urandom));
      end else begin
        m = model(op, x, y, s);
        single_op("rand", op, x, y, s, m[31:0], m[32]);
      end
    end
    start = 1'b0;
    tick();
    check("end.no_done", done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, tests %0d", tests);
    $fatal(1, "timeout");
  end

endmodule
